// File: rtl/rob_unit_pkg.sv
// Shared core package for the reorder buffer: default depth and the entry record.
package rob_unit_pkg;

  // Default number of ROB entries (power of two, at least 4).
  localparam int unsigned ROB_LEN = 8;

  // One in-flight instruction. done is set by writeback or store acknowledge.
  typedef struct packed {
    logic        done;
    logic [6:0]  rd;
    logic [31:0] data;
    logic [31:0] pc;
    logic        is_store;
  } rob_entry_t;

endpackage

// File: rtl/rob_unit_if.sv
// Reorder buffer bus: dispatch, writeback, store ack, mispredict and commit groups.
// master = pipeline side driving the ROB, slave = the ROB itself.
interface rob_unit_if #(
  parameter int unsigned IDX_W = 3
);
  logic             disp_valid;
  logic             disp_ready;
  logic [6:0]       disp_rd;
  logic [31:0]      disp_pc;
  logic             disp_is_store;
  logic [IDX_W-1:0] disp_rob_idx;

  logic             wb_valid;
  logic [IDX_W-1:0] wb_rob_idx;
  logic [31:0]      wb_data;

  logic             st_ack_valid;
  logic [IDX_W-1:0] st_ack_rob_idx;

  logic             mis_valid;
  logic [IDX_W-1:0] mis_rob_idx;

  logic             commit_valid;
  logic             commit_ready;
  logic [6:0]       commit_rd;
  logic [31:0]      commit_data;
  logic [31:0]      commit_pc;
  logic             commit_is_store;
  logic [IDX_W-1:0] commit_rob_idx;

  logic             empty;
  logic             full;

  modport master (
    output disp_valid, disp_rd, disp_pc, disp_is_store,
    output wb_valid, wb_rob_idx, wb_data,
    output st_ack_valid, st_ack_rob_idx,
    output mis_valid, mis_rob_idx,
    output commit_ready,
    input  disp_ready, disp_rob_idx,
    input  commit_valid, commit_rd, commit_data, commit_pc, commit_is_store, commit_rob_idx,
    input  empty, full
  );

  modport slave (
    input  disp_valid, disp_rd, disp_pc, disp_is_store,
    input  wb_valid, wb_rob_idx, wb_data,
    input  st_ack_valid, st_ack_rob_idx,
    input  mis_valid, mis_rob_idx,
    input  commit_ready,
    output disp_ready, disp_rob_idx,
    output commit_valid, commit_rd, commit_data, commit_pc, commit_is_store, commit_rob_idx,
    output empty, full
  );

endinterface

// File: rtl/rob_unit.sv
// Reorder buffer: circular flop array with in-order allocate and commit,
// out-of-order completion, and mispredict flush of younger entries.
// Optional macro ROB_WB_BYPASS_EN: a writeback to the head entry commits in the same cycle.
module rob_unit
  import rob_unit_pkg::*;
#(
  parameter int unsigned ROB_LEN = rob_unit_pkg::ROB_LEN,
  parameter int unsigned IDX_W   = $clog2(ROB_LEN)
) (
  input logic        clk,
  input logic        rst,
  rob_unit_if.slave  bus
);

  localparam int unsigned CNT_W = IDX_W + 1;

  rob_entry_t       entries_q [ROB_LEN];
  rob_entry_t       entries_d [ROB_LEN];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  rob_entry_t       head_entry;
  logic             empty_w, full_w;
  logic             alloc, commit_fire, bypass_hit, commit_valid_w;
  logic [IDX_W-1:0] mis_off, wb_off, ack_off;
  logic             wb_live, ack_live;

  assign head_entry = entries_q[head_q];
  assign empty_w    = (count_q == '0);
  assign full_w     = (count_q == CNT_W'(ROB_LEN));

  // Distance from head; modulo arithmetic is free since ROB_LEN is a power of two.
  assign mis_off = bus.mis_rob_idx - head_q;
  assign wb_off  = bus.wb_rob_idx - head_q;
  assign ack_off = bus.st_ack_rob_idx - head_q;

`ifdef ROB_WB_BYPASS_EN
  assign bypass_hit = bus.wb_valid && (bus.wb_rob_idx == head_q) && !empty_w;
`else
  assign bypass_hit = 1'b0;
`endif

  assign commit_valid_w = !rst && !empty_w && (head_entry.done || bypass_hit);
  assign commit_fire    = commit_valid_w && bus.commit_ready;

  // Dispatch never sees a slot freed by a same-cycle commit.
  assign bus.disp_ready   = !rst && !full_w && !bus.mis_valid;
  assign bus.disp_rob_idx = tail_q;
  assign alloc            = bus.disp_valid && bus.disp_ready;

  assign bus.commit_valid    = commit_valid_w;
  assign bus.commit_rd       = head_entry.rd;
  assign bus.commit_data     = bypass_hit ? bus.wb_data : head_entry.data;
  assign bus.commit_pc       = head_entry.pc;
  assign bus.commit_is_store = head_entry.is_store;
  assign bus.commit_rob_idx  = head_q;

  assign bus.empty = rst || empty_w;
  assign bus.full  = !rst && full_w;

  // Completion is accepted only for allocated entries that survive a same-cycle flush.
  always_comb begin
    wb_live  = bus.wb_valid && ({1'b0, wb_off} < count_q) &&
               !(bus.mis_valid && (wb_off > mis_off));
    ack_live = bus.st_ack_valid && ({1'b0, ack_off} < count_q) &&
               !(bus.mis_valid && (ack_off > mis_off));
  end

  // Entry array next state: allocate, complete, flush younger, retire head.
  always_comb begin
    entries_d = entries_q;
    if (alloc) begin
      entries_d[tail_q].done     = 1'b0;
      entries_d[tail_q].rd       = bus.disp_rd;
      entries_d[tail_q].data     = '0;
      entries_d[tail_q].pc       = bus.disp_pc;
      entries_d[tail_q].is_store = bus.disp_is_store;
    end
    if (ack_live) begin
      entries_d[bus.st_ack_rob_idx].done = 1'b1;
    end
    if (wb_live) begin
      entries_d[bus.wb_rob_idx].done = 1'b1;
      entries_d[bus.wb_rob_idx].data = bus.wb_data;
    end
    if (bus.mis_valid) begin
      for (int i = 0; i < int'(ROB_LEN); i++) begin
        if ((IDX_W'(i) - head_q) > mis_off) begin
          entries_d[i].done = 1'b0;
        end
      end
    end
    if (commit_fire) begin
      entries_d[head_q].done = 1'b0;
    end
  end

  // Pointer and occupancy next state; a mispredict rebuilds count from the branch position.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (commit_fire) begin
      head_d = head_q + IDX_W'(1);
    end
    if (bus.mis_valid) begin
      tail_d  = bus.mis_rob_idx + IDX_W'(1);
      count_d = CNT_W'(mis_off) + CNT_W'(1) - CNT_W'(commit_fire);
    end else begin
      if (alloc) begin
        tail_d = tail_q + IDX_W'(1);
      end
      count_d = count_q + CNT_W'(alloc) - CNT_W'(commit_fire);
    end
  end

  // State registers with synchronous reset that drops every entry without committing.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(ROB_LEN); i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

endmodule

// File: tb/tb_rob_unit.sv
// Self-checking bench for rob_unit: vector table for fill/complete/commit order,
// plus directed sequences for full+commit, commit stall, mispredict wrap and bypass timing.
module tb_rob_unit;
  localparam int unsigned ROB_LEN = 8;
  localparam int unsigned IDX_W   = 3;
`ifdef ROB_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_unit_if #(.IDX_W(IDX_W)) bus ();

  rob_unit #(.ROB_LEN(ROB_LEN), .IDX_W(IDX_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        dv;
    logic [6:0]  rd;
    logic [31:0] pc;
    logic        st;
    logic        wv;
    logic [2:0]  wi;
    logic [31:0] wd;
    logic        cr;
    logic        e_dr;
    logic [2:0]  e_didx;
    logic        e_cv;
    logic [2:0]  e_cidx;
    logic [6:0]  e_crd;
    logic [31:0] e_cpc;
    logic [31:0] e_cdata;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vec [14];

  function automatic vec_t mk(input logic dv, input logic [6:0] rd, input logic [31:0] pc,
                              input logic st, input logic wv, input logic [2:0] wi,
                              input logic [31:0] wd, input logic cr, input logic e_dr,
                              input logic [2:0] e_didx, input logic e_cv,
                              input logic [2:0] e_cidx, input logic [6:0] e_crd,
                              input logic [31:0] e_cpc, input logic [31:0] e_cdata,
                              input logic e_full, input logic e_empty);
    vec_t v;
    v.dv = dv; v.rd = rd; v.pc = pc; v.st = st;
    v.wv = wv; v.wi = wi; v.wd = wd; v.cr = cr;
    v.e_dr = e_dr; v.e_didx = e_didx; v.e_cv = e_cv; v.e_cidx = e_cidx;
    v.e_crd = e_crd; v.e_cpc = e_cpc; v.e_cdata = e_cdata;
    v.e_full = e_full; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    bus.disp_valid     = 1'b0;
    bus.disp_rd        = '0;
    bus.disp_pc        = '0;
    bus.disp_is_store  = 1'b0;
    bus.wb_valid       = 1'b0;
    bus.wb_rob_idx     = '0;
    bus.wb_data        = '0;
    bus.st_ack_valid   = 1'b0;
    bus.st_ack_rob_idx = '0;
    bus.mis_valid      = 1'b0;
    bus.mis_rob_idx    = '0;
    bus.commit_ready   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    #1;
    chk("rst disp_ready", 32'(bus.disp_ready), 0);
    chk("rst empty", 32'(bus.empty), 1);
    chk("rst full", 32'(bus.full), 0);
    chk("rst commit_valid", 32'(bus.commit_valid), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post-rst disp_ready", 32'(bus.disp_ready), 1);
    chk("post-rst disp_rob_idx", 32'(bus.disp_rob_idx), 0);
  endtask

  task automatic disp(input logic [6:0] rd, input logic [31:0] pc, input logic st,
                      input logic [2:0] exp_idx);
    bus.disp_valid    = 1'b1;
    bus.disp_rd       = rd;
    bus.disp_pc       = pc;
    bus.disp_is_store = st;
    #1;
    chk("disp idx", 32'(bus.disp_rob_idx), 32'(exp_idx));
    chk("disp ready", 32'(bus.disp_ready), 1);
    tick();
    bus.disp_valid    = 1'b0;
    bus.disp_is_store = 1'b0;
  endtask

  task automatic wb(input logic [2:0] idx, input logic [31:0] data);
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = idx;
    bus.wb_data    = data;
    tick();
    bus.wb_valid   = 1'b0;
  endtask

  initial begin
    // Fill 8, complete 1 then 0, commit in order.
    for (int i = 0; i < 8; i++) begin
      vec[i] = mk(1'b1, 7'(i + 1), 32'h100 + 32'(4 * i), 1'b0, 1'b0, 3'd0, 32'h0, 1'b1,
                  1'b1, 3'(i), 1'b0, 3'd0, 7'd0, 32'h0, 32'h0, 1'b0, (i == 0));
    end
    vec[8]  = mk(1'b1, 7'h9, 32'h200, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1,
                 1'b0, 3'd0, 1'b0, 3'd0, 7'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    vec[9]  = mk(1'b0, 7'h0, 32'h0, 1'b0, 1'b1, 3'd1, 32'h11, 1'b1,
                 1'b0, 3'd0, 1'b0, 3'd0, 7'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    vec[10] = mk(1'b0, 7'h0, 32'h0, 1'b0, 1'b1, 3'd0, 32'h10, 1'b0,
                 1'b0, 3'd0, BYP, 3'd0, 7'd1, 32'h100, 32'h10, 1'b1, 1'b0);
    vec[11] = mk(1'b0, 7'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1,
                 1'b0, 3'd0, 1'b1, 3'd0, 7'd1, 32'h100, 32'h10, 1'b1, 1'b0);
    vec[12] = mk(1'b0, 7'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1,
                 1'b1, 3'd0, 1'b1, 3'd1, 7'd2, 32'h104, 32'h11, 1'b0, 1'b0);
    vec[13] = mk(1'b0, 7'h0, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b1,
                 1'b1, 3'd0, 1'b0, 3'd2, 7'd3, 32'h108, 32'h0, 1'b0, 1'b0);

    rst = 1'b1;
    idle();
    tick();
    do_reset();

    for (int i = 0; i < 14; i++) begin
      bus.disp_valid    = vec[i].dv;
      bus.disp_rd       = vec[i].rd;
      bus.disp_pc       = vec[i].pc;
      bus.disp_is_store = vec[i].st;
      bus.wb_valid      = vec[i].wv;
      bus.wb_rob_idx    = vec[i].wi;
      bus.wb_data       = vec[i].wd;
      bus.commit_ready  = vec[i].cr;
      #1;
      chk($sformatf("v%0d disp_ready", i), 32'(bus.disp_ready), 32'(vec[i].e_dr));
      chk($sformatf("v%0d disp_rob_idx", i), 32'(bus.disp_rob_idx), 32'(vec[i].e_didx));
      chk($sformatf("v%0d commit_valid", i), 32'(bus.commit_valid), 32'(vec[i].e_cv));
      chk($sformatf("v%0d full", i), 32'(bus.full), 32'(vec[i].e_full));
      chk($sformatf("v%0d empty", i), 32'(bus.empty), 32'(vec[i].e_empty));
      if (vec[i].e_cv) begin
        chk($sformatf("v%0d commit_rob_idx", i), 32'(bus.commit_rob_idx), 32'(vec[i].e_cidx));
        chk($sformatf("v%0d commit_rd", i), 32'(bus.commit_rd), 32'(vec[i].e_crd));
        chk($sformatf("v%0d commit_pc", i), bus.commit_pc, vec[i].e_cpc);
        chk($sformatf("v%0d commit_data", i), bus.commit_data, vec[i].e_cdata);
      end
      tick();
    end
    idle();

    // Full ROB: commit fires, same-cycle dispatch refused.
    do_reset();
    for (int i = 0; i < 8; i++) disp(7'(i + 1), 32'h300 + 32'(4 * i), 1'b0, 3'(i));
    wb(3'd0, 32'h55);
    bus.disp_valid   = 1'b1;
    bus.disp_rd      = 7'h3f;
    bus.commit_ready = 1'b1;
    #1;
    chk("full+commit commit_valid", 32'(bus.commit_valid), 1);
    chk("full+commit disp_ready", 32'(bus.disp_ready), 0);
    chk("full+commit data", bus.commit_data, 32'h55);
    tick();
    idle();
    #1;
    chk("full+commit count", 32'(dut.count_q), 7);
    chk("full+commit full", 32'(bus.full), 0);
    chk("full+commit tail", 32'(bus.disp_rob_idx), 0);
    chk("full+commit head", 32'(bus.commit_rob_idx), 1);

    // Commit stall: done head held with stable fields.
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = 3'd1;
    bus.wb_data    = 32'hABCD;
    tick();
    bus.wb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall commit_valid", 32'(bus.commit_valid), 1);
      chk("stall commit_data", bus.commit_data, 32'hABCD);
      chk("stall commit_rd", 32'(bus.commit_rd), 2);
      chk("stall commit_pc", bus.commit_pc, 32'h304);
      chk("stall count", 32'(dut.count_q), 7);
      tick();
    end
    bus.commit_ready = 1'b1;
    tick();
    bus.commit_ready = 1'b0;
    #1;
    chk("stall release count", 32'(dut.count_q), 6);
    chk("stall release head", 32'(bus.commit_rob_idx), 2);

    // Mispredict across the wrap point: head=6, entries 6,7,0,1, branch at 7.
    do_reset();
    for (int i = 0; i < 6; i++) disp(7'(i + 1), 32'h400 + 32'(4 * i), 1'b0, 3'(i));
    bus.commit_ready = 1'b1;
    for (int i = 0; i < 6; i++) wb(3'(i), 32'(i));
    tick();
    tick();
    bus.commit_ready = 1'b0;
    #1;
    chk("wrap empty", 32'(bus.empty), 1);
    chk("wrap tail", 32'(bus.disp_rob_idx), 6);
    disp(7'h21, 32'h500, 1'b0, 3'd6);
    disp(7'h00, 32'h504, 1'b1, 3'd7);
    disp(7'h41, 32'h508, 1'b0, 3'd0);
    disp(7'h22, 32'h50c, 1'b0, 3'd1);
    bus.mis_valid   = 1'b1;
    bus.mis_rob_idx = 3'd7;
    bus.wb_valid    = 1'b1;
    bus.wb_rob_idx  = 3'd0;
    bus.wb_data     = 32'h99;
    #1;
    chk("mis disp_ready", 32'(bus.disp_ready), 0);
    tick();
    bus.mis_valid = 1'b0;
    bus.wb_data   = 32'h77;
    #1;
    chk("mis tail", 32'(bus.disp_rob_idx), 0);
    chk("mis count", 32'(dut.count_q), 2);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("mis idx0 done", 32'(dut.entries_q[0].done), 0);
    chk("mis idx1 done", 32'(dut.entries_q[1].done), 0);
    chk("mis commit_valid", 32'(bus.commit_valid), 0);
    bus.wb_valid       = 1'b1;
    bus.wb_rob_idx     = 3'd6;
    bus.wb_data        = 32'h66;
    bus.st_ack_valid   = 1'b1;
    bus.st_ack_rob_idx = 3'd7;
    tick();
    bus.wb_valid     = 1'b0;
    bus.st_ack_valid = 1'b0;
    #1;
    chk("mis c6 valid", 32'(bus.commit_valid), 1);
    chk("mis c6 idx", 32'(bus.commit_rob_idx), 6);
    chk("mis c6 data", bus.commit_data, 32'h66);
    chk("mis c6 rd", 32'(bus.commit_rd), 32'h21);
    bus.commit_ready = 1'b1;
    tick();
    #1;
    chk("mis c7 valid", 32'(bus.commit_valid), 1);
    chk("mis c7 idx", 32'(bus.commit_rob_idx), 7);
    chk("mis c7 store", 32'(bus.commit_is_store), 1);
    chk("mis c7 data", bus.commit_data, 32'h0);
    chk("mis c7 pc", bus.commit_pc, 32'h504);
    tick();
    #1;
    chk("mis drained commit_valid", 32'(bus.commit_valid), 0);
    chk("mis drained empty", 32'(bus.empty), 1);
    idle();

    // Writeback to head idx 2: same-cycle commit only with the bypass build.
    do_reset();
    for (int i = 0; i < 3; i++) disp(7'(i + 1), 32'h600 + 32'(4 * i), 1'b0, 3'(i));
    bus.commit_ready = 1'b1;
    wb(3'd0, 32'hA0);
    wb(3'd1, 32'hA1);
    tick();
    tick();
    #1;
    chk("byp head", 32'(bus.commit_rob_idx), 2);
    chk("byp pre commit_valid", 32'(bus.commit_valid), 0);
    bus.wb_valid   = 1'b1;
    bus.wb_rob_idx = 3'd2;
    bus.wb_data    = 32'hDEADBEEF;
    #1;
    chk("byp same-cycle commit_valid", 32'(bus.commit_valid), 32'(BYP));
    chk("byp same-cycle commit_data", bus.commit_data, BYP ? 32'hDEADBEEF : 32'h0);
    tick();
    bus.wb_valid = 1'b0;
    #1;
    chk("byp next commit_valid", 32'(bus.commit_valid), 32'(!BYP));
    chk("byp next commit_data", bus.commit_data, BYP ? 32'h0 : 32'hDEADBEEF);
    chk("byp next empty", 32'(bus.empty), 32'(BYP));
    tick();
    #1;
    chk("byp final empty", 32'(bus.empty), 1);
    chk("byp final commit_valid", 32'(bus.commit_valid), 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
